// File: rtl/mem_wr_ctrl_pkg.sv
// rtl/mem_wr_ctrl_pkg.sv - shared AXI response codes and write FSM states
package mem_wr_ctrl_pkg;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;
    localparam logic [1:0] BRESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } wr_state_e;

endpackage

// File: rtl/mem_wr_ctrl_store_fifo.sv
// rtl/mem_wr_ctrl_store_fifo.sv - store buffer FIFO with registered count
module store_fifo #(
    parameter int  DEPTH = 4,
    parameter int  W     = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  head_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    // DEPTH is a power of two, so pointers wrap by plain overflow
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mem_wr_ctrl.sv
// rtl/mem_wr_ctrl.sv - buffered store issue on AXI4-Lite AW/W/B; MEM_WR_ERR_EN adds WR_ERR/WR_ERR_ADDR
module mem_wr_ctrl
    import mem_wr_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          HOLD,
    input  logic          M_VALID,
    input  logic          M_STORE_WREN,
    input  logic [AW-1:0] M_STORE_ADDR,
    input  logic [3:0]    M_STORE_STRB,
    input  logic [31:0]   M_STORE_DATA,
    output logic          STALL,
    output logic          EMPTY,
    output logic [AW-1:0] AWADDR,
    output logic          AWVALID,
    input  logic          AWREADY,
    output logic [31:0]   WDATA,
    output logic [3:0]    WSTRB,
    output logic          WVALID,
    input  logic          WREADY,
    input  logic [1:0]    BRESP,
    input  logic          BVALID,
    output logic          BREADY
`ifdef MEM_WR_ERR_EN
    ,
    output logic          WR_ERR,
    output logic [AW-1:0] WR_ERR_ADDR
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = (AW - 2) + 4 + 32;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    wr_state_e     state_q, state_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          bready_q, bready_d;
    logic [AW-1:0] awaddr_q, awaddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;

    logic          req, push, pop;
    logic [EW-1:0] entry, head;
    logic [CW-1:0] count;

    assign req   = M_VALID & M_STORE_WREN & (M_STORE_STRB != 4'b0000);
    // Full is judged on the registered count: a same-cycle pop never frees the slot
    assign push  = req & ~HOLD & (count != FULL_CNT);
    assign STALL = req & (count == FULL_CNT);
    assign EMPTY = (count == '0) & (state_q == ST_IDLE);
    assign entry = {M_STORE_ADDR[AW-1:2], M_STORE_STRB, M_STORE_DATA};

    store_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RSTN),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (entry),
        .head_o  (head),
        .count_o (count)
    );

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count != '0) begin
                    awaddr_d  = {head[EW-1 -: AW-2], 2'b00};
                    wstrb_d   = head[35:32];
                    wdata_d   = head[31:0];
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (AWREADY) awvalid_d = 1'b0;
                if (WREADY)  wvalid_d  = 1'b0;
                if ((~awvalid_q | AWREADY) & (~wvalid_q | WREADY)) begin
                    bready_d = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                if (BVALID) begin
                    pop      = 1'b1;
                    bready_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= ST_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    assign AWADDR  = awaddr_q;
    assign AWVALID = awvalid_q;
    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign WVALID  = wvalid_q;
    assign BREADY  = bready_q;

`ifdef MEM_WR_ERR_EN
    logic          wr_err_q;
    logic [AW-1:0] wr_err_addr_q;
    logic          unused_lsb;

    // awaddr_q still holds the failing store's address while in RESP
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_err_q      <= 1'b0;
            wr_err_addr_q <= '0;
        end else if ((state_q == ST_RESP) && BVALID && (BRESP != BRESP_OKAY) && !wr_err_q) begin
            wr_err_q      <= 1'b1;
            wr_err_addr_q <= awaddr_q;
        end
    end

    assign WR_ERR      = wr_err_q;
    assign WR_ERR_ADDR = wr_err_addr_q;
    assign unused_lsb  = ^M_STORE_ADDR[1:0];
`else
    logic unused_lsb;
    assign unused_lsb = ^{M_STORE_ADDR[1:0], BRESP};
`endif

endmodule
